// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one memory read per start request, captures the
// returned word for the instruction register and maintains the program counter.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        input_IF_start,
  input  logic        input_IF_PCWrite,
  input  logic [15:0] input_IF_PCTarget,
  input  logic [15:0] input_IF_MemRdata,
  input  logic        input_IF_MemReady,
  output logic        Output_IF_MemReq,
  output logic [15:0] Output_IF_MemAddr,
  output logic [15:0] Output_IF_Instru,
  output logic        Output_IF_IRWrite,
  output logic [15:0] Output_IF_PC,
  output logic [15:0] Output_IF_PCNext,
  output logic        Output_IF_Busy,
  output logic        Output_IF_Fault,
  output logic [1:0]  dbg_state
);

  // Memory handshake: MemReq is held high with MemAddr stable for the whole WAIT
  // state; the read completes on the first rising edge in WAIT with MemReady=1.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [15:0] RESET_PC_EVEN = {RESET_PC[15:1], 1'b0};
  localparam logic [7:0]  TO_LAST       = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instru_q, instru_d;
  logic [15:0] cap_pc_q, cap_pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pend_v_q, pend_v_d;
  logic [15:0] pend_t_q, pend_t_d;
  logic        req_q, req_d;
  logic        irw_q, irw_d;
  logic        fault_q, fault_d;
  logic [15:0] target;

  assign target = {input_IF_PCTarget[15:1], 1'b0};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    instru_d = instru_q;
    cap_pc_d = cap_pc_q;
    cnt_d    = cnt_q;
    pend_v_d = pend_v_q;
    pend_t_d = pend_t_q;
    req_d    = 1'b0;
    irw_d    = 1'b0;
    fault_d  = fault_q;
    case (state_q)
      S_IDLE: begin
        if (input_IF_PCWrite) pc_d = target;
        if (input_IF_start) begin
          addr_d   = input_IF_PCWrite ? target : pc_q;
          cnt_d    = 8'd0;
          pend_v_d = 1'b0;
          req_d    = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        req_d = 1'b1;
        // A redirect arriving mid-fetch is deferred; the latest target wins.
        if (input_IF_PCWrite) begin
          pend_v_d = 1'b1;
          pend_t_d = target;
        end
        if (input_IF_MemReady) begin
          instru_d = input_IF_MemRdata;
          cap_pc_d = addr_q;
          if (input_IF_PCWrite)  pc_d = target;
          else if (pend_v_q)     pc_d = pend_t_q;
          else                   pc_d = addr_q + 16'd2;
          pend_v_d = 1'b0;
          req_d    = 1'b0;
          irw_d    = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          pend_v_d = 1'b0;
          req_d    = 1'b0;
          fault_d  = 1'b1;
          state_d  = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (input_IF_PCWrite) pc_d = target;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        fault_d = 1'b1;
        if (input_IF_PCWrite) begin
          pc_d    = target;
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC_EVEN;
      addr_q   <= 16'h0000;
      instru_q <= 16'h0000;
      cap_pc_q <= 16'h0000;
      cnt_q    <= 8'd0;
      pend_v_q <= 1'b0;
      pend_t_q <= 16'h0000;
      req_q    <= 1'b0;
      irw_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      instru_q <= instru_d;
      cap_pc_q <= cap_pc_d;
      cnt_q    <= cnt_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
      req_q    <= req_d;
      irw_q    <= irw_d;
      fault_q  <= fault_d;
    end
  end

  assign Output_IF_MemReq  = req_q;
  assign Output_IF_MemAddr = addr_q;
  assign Output_IF_Instru  = instru_q;
  assign Output_IF_IRWrite = irw_q;
  assign Output_IF_PC      = cap_pc_q;
  assign Output_IF_PCNext  = pc_q + 16'd2;
  assign Output_IF_Busy    = (state_q != S_IDLE);
  assign Output_IF_Fault   = fault_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized fetches,
// scored against a program-counter model; captures are checked by a monitor.
module tb_instruction_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          TIMEOUT  = 15;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start, pcwrite, memready;
  logic [15:0] pctarget, memrdata;
  logic        memreq, irwrite, busy, fault;
  logic [15:0] memaddr, instru, out_pc, pcnext;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected capture: {instruction, captured address, program counter after capture}
  logic [47:0] exp_q[$];

  logic [15:0] model_pc;
  logic [15:0] last_instru;
  logic [15:0] last_cpc;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .input_IF_start    (start),
    .input_IF_PCWrite  (pcwrite),
    .input_IF_PCTarget (pctarget),
    .input_IF_MemRdata (memrdata),
    .input_IF_MemReady (memready),
    .Output_IF_MemReq  (memreq),
    .Output_IF_MemAddr (memaddr),
    .Output_IF_Instru  (instru),
    .Output_IF_IRWrite (irwrite),
    .Output_IF_PC      (out_pc),
    .Output_IF_PCNext  (pcnext),
    .Output_IF_Busy    (busy),
    .Output_IF_Fault   (fault),
    .dbg_state         (dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every IRWrite pulse must match the oldest outstanding expected capture.
  always @(negedge CLK) begin
    if (irwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_irwrite: got IRWrite=1 expected no capture at %0t", $time);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        chk("cap_instru", instru, e[47:32]);
        chk("cap_pc", out_pc, e[31:16]);
        chk("cap_pcnext", pcnext, e[15:0] + 16'd2);
      end
    end
  end

  task automatic idle_cycle(input bit pw, input logic [15:0] tgt);
    start    = 1'b0;
    pcwrite  = pw;
    pctarget = tgt;
    memready = 1'($urandom_range(0, 1));
    memrdata = 16'($urandom);
    @(posedge CLK); #1;
    pcwrite  = 1'b0;
    memready = 1'b0;
    if (pw) model_pc = tgt & 16'hFFFE;
    chk("idle_pcnext", pcnext, model_pc + 16'd2);
    chk("hold_instru", instru, last_instru);
    chk("hold_pc", out_pc, last_cpc);
    chk1("idle_memreq", memreq, 1'b0);
  endtask

  // Caller is at posedge+1 in IDLE. k = WAIT edge on which MemReady is given.
  task automatic do_fetch(input bit pw, input logic [15:0] tgt, input int k,
                          input logic [15:0] rdata, input int redir_cyc,
                          input logic [15:0] redir_tgt, input bit done_pw,
                          input logic [15:0] done_tgt);
    logic [15:0] addr, nxt, pend_t;
    bit pend;
    pend   = 1'b0;
    pend_t = 16'h0000;
    start    = 1'b1;
    pcwrite  = pw;
    pctarget = tgt;
    memready = 1'($urandom_range(0, 1));
    if (pw) model_pc = tgt & 16'hFFFE;
    addr = model_pc;
    @(posedge CLK); #1;
    start = 1'b0; pcwrite = 1'b0; memready = 1'b0;
    chk("wait_memaddr", memaddr, addr);
    chk1("wait_memreq", memreq, 1'b1);
    chk1("wait_busy", busy, 1'b1);
    for (int c = 1; c <= k; c++) begin
      start = 1'($urandom_range(0, 1));
      if (c == redir_cyc) begin
        pcwrite  = 1'b1;
        pctarget = redir_tgt;
        pend     = 1'b1;
        pend_t   = redir_tgt & 16'hFFFE;
      end
      memready = (c == k);
      memrdata = (c == k) ? rdata : 16'($urandom);
      if (c == k) begin
        nxt = pend ? pend_t : addr + 16'd2;
        exp_q.push_back({rdata, addr, nxt});
      end
      @(posedge CLK); #1;
      start = 1'b0; pcwrite = 1'b0; memready = 1'b0;
      if (c < k) begin
        chk1("wait_memreq_held", memreq, 1'b1);
        chk("wait_memaddr_held", memaddr, addr);
      end
    end
    model_pc    = nxt;
    last_instru = rdata;
    last_cpc    = addr;
    chk1("done_memreq", memreq, 1'b0);
    chk1("done_irwrite", irwrite, 1'b1);
    pcwrite  = done_pw;
    pctarget = done_tgt;
    start    = 1'($urandom_range(0, 1));
    memready = 1'($urandom_range(0, 1));
    @(posedge CLK); #1;
    start = 1'b0; pcwrite = 1'b0; memready = 1'b0;
    if (done_pw) model_pc = done_tgt & 16'hFFFE;
    chk1("post_irwrite", irwrite, 1'b0);
    chk1("post_busy", busy, 1'b0);
    chk("post_pcnext", pcnext, model_pc + 16'd2);
  endtask

  task automatic timeout_test();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; memready = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(posedge CLK); #1;
      if (c == TIMEOUT - 1) begin
        chk1("to_fault_early", fault, 1'b0);
        chk1("to_memreq_early", memreq, 1'b1);
      end
    end
    chk1("to_fault", fault, 1'b1);
    chk1("to_memreq", memreq, 1'b0);
    chk1("to_busy", busy, 1'b1);
    for (int c = 0; c < 3; c++) begin
      start = 1'b1; memready = 1'b1;
      @(posedge CLK); #1;
      chk1("fault_sticky", fault, 1'b1);
      chk1("fault_no_req", memreq, 1'b0);
    end
    start = 1'b0; memready = 1'b0;
    pcwrite = 1'b1; pctarget = 16'h0020;
    @(posedge CLK); #1;
    pcwrite = 1'b0;
    model_pc = 16'h0020;
    chk1("fault_clear", fault, 1'b0);
    chk1("fault_exit_idle", busy, 1'b0);
    chk("fault_exit_pcnext", pcnext, 16'h0022);
  endtask

  task automatic reset_mid_wait();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk1("rst_memreq", memreq, 1'b0);
    chk1("rst_irwrite", irwrite, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_pcnext", pcnext, RESET_PC + 16'd2);
    chk("rst_memaddr", memaddr, 16'h0000);
    chk("rst_instru", instru, 16'h0000);
    chk("rst_outpc", out_pc, 16'h0000);
    memready = 1'b1;
    memrdata = 16'hDEAD;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_pc    = RESET_PC;
    last_instru = 16'h0000;
    last_cpc    = 16'h0000;
    idle_cycle(1'b0, 16'h0000);
    idle_cycle(1'b0, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    start = 1'b0; pcwrite = 1'b0; memready = 1'b0;
    pctarget = 16'h0000; memrdata = 16'h0000;
    model_pc = RESET_PC; last_instru = 16'h0000; last_cpc = 16'h0000;
    #1;
    chk1("reset_memreq", memreq, 1'b0);
    chk1("reset_fault", fault, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk("reset_pcnext", pcnext, RESET_PC + 16'd2);
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    idle_cycle(1'b0, 16'h0000);

    do_fetch(1'b0, 16'h0000, 1, 16'hA5C3, 0, 16'h0000, 1'b0, 16'h0000);
    idle_cycle(1'b1, 16'hFFFE);
    do_fetch(1'b0, 16'h0000, 3, 16'h1111, 0, 16'h0000, 1'b0, 16'h0000);
    do_fetch(1'b1, 16'h1235, 2, 16'h2222, 0, 16'h0000, 1'b0, 16'h0000);
    idle_cycle(1'b1, 16'h0010);
    do_fetch(1'b0, 16'h0000, 3, 16'h3333, 2, 16'h0400, 1'b0, 16'h0000);
    do_fetch(1'b0, 16'h0000, TIMEOUT, 16'h4444, 0, 16'h0000, 1'b0, 16'h0000);
    timeout_test();
    idle_cycle(1'b0, 16'h0000);
    reset_mid_wait();

    for (int i = 0; i < 60; i++) begin
      int k, rc;
      k  = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(1, 5);
      rc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, k) : 0;
      do_fetch(($urandom_range(0, 3) == 0), 16'($urandom), k, 16'($urandom),
               rc, 16'($urandom), ($urandom_range(0, 4) == 0), 16'($urandom));
      repeat ($urandom_range(0, 2)) idle_cycle(($urandom_range(0, 4) == 0), 16'($urandom));
    end

    idle_cycle(1'b0, 16'h0000);
    chk("queue_empty", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning PC value loaded on reset (bit 0 always 0).
REQ-002 SHALL have parameter TIMEOUT, default 15, range 1..255, meaning max WAIT cycles before fault.
REQ-003 SHALL have port CLK  in  1  rising-edge clock.
REQ-004 SHALL have port RST_N  in  1  asynchronous active-low reset.
REQ-005 SHALL have port input_IF_start  in  1  fetch request from control FSM, sampled only in IDLE.
REQ-006 SHALL have port input_IF_PCWrite  in  1  load PC with target (branch/jump redirect).
REQ-007 SHALL have port input_IF_PCTarget  in  16  redirect target; bit 0 ignored.
REQ-008 SHALL have port input_IF_MemRdata  in  16  instruction word from memory.
REQ-009 SHALL have port input_IF_MemReady  in  1  memory data valid, sampled only in WAIT.
REQ-010 SHALL have port Output_IF_MemReq  out  1  memory read request, registered.
REQ-011 SHALL have port Output_IF_MemAddr  out  16  fetch address, registered, stable while MemReq=1.
REQ-012 SHALL have port Output_IF_Instru  out  16  captured instruction, feeds instruction register data input.
REQ-013 SHALL have port Output_IF_IRWrite  out  1  one-cycle pulse, feeds instruction register write enable.
REQ-014 SHALL have port Output_IF_PC  out  16  address of the last captured instruction.
REQ-015 SHALL have port Output_IF_PCNext  out  16  current PC + 2 mod 2^16, combinational.
REQ-016 SHALL have ports Output_IF_Busy  out  1  (state != IDLE) and Output_IF_Fault  out  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, DONE, FAULT, all transitions on rising CLK.
REQ-018 IDLE: MemReq=0; on start=1 SHALL load MemAddr <= (PCWrite ? {PCTarget[15:1],1'b0} : PC), clear timeout counter, go WAIT.
REQ-019 WAIT: MemReq=1, MemAddr held; on MemReady=1 SHALL capture Instru <= MemRdata, Output_IF_PC <= MemAddr, go DONE.
REQ-020 WAIT with MemReady=0 SHALL increment counter; when the TIMEOUT-th consecutive WAIT cycle ends without MemReady, SHALL go FAULT and set Fault=1.
REQ-021 DONE: IRWrite=1 for exactly one cycle, MemReq=0, then unconditionally IDLE.
REQ-022 Latency: start sampled at edge N, MemReady=1 at edge N+k (k>=1) -> IRWrite high in cycle after edge N+k; minimum 2 edges.
REQ-023 PC update on WAIT->DONE SHALL be PC <= MemAddr + 2, unless a redirect is pending, then PC <= pending target.
REQ-024 PCWrite in IDLE, DONE or FAULT SHALL load PC <= {PCTarget[15:1],1'b0} at that edge, priority over increment.
REQ-025 PCWrite in WAIT SHALL not disturb MemAddr; target SHALL be stored as pending redirect (latest wins), applied at WAIT->DONE.
REQ-026 FAULT: MemReq=0, start ignored, Fault=1 held; PCWrite SHALL load PC, clear Fault, go IDLE; otherwise exit only by reset.
REQ-027 start outside IDLE and MemReady outside WAIT SHALL be ignored; no queuing.
REQ-028 PC arithmetic SHALL wrap: 16'hFFFE + 2 = 16'h0000; PC[0] SHALL always be 0.
REQ-029 Output_IF_Instru and Output_IF_PC SHALL hold value until next capture.

Reset
REQ-030 RST_N=0 SHALL immediately (asynchronously) force state IDLE, PC=RESET_PC, MemReq=0, MemAddr=0, Instru=0, IRWrite=0, Output_IF_PC=0, Fault=0, counter=0, pending redirect cleared.
REQ-031 Reset during WAIT or DONE SHALL drop MemReq/IRWrite at once; the interrupted fetch SHALL produce no IRWrite after release.
REQ-032 After RST_N rises, first action SHALL occur no earlier than the first rising CLK with RST_N=1.

Verification
REQ-033 Reset, start=1 one cycle, MemReady=1 first WAIT cycle, Rdata=16'hA5C3 -> MemAddr=0000, IRWrite pulse 2 edges after start, Instru=A5C3, PC=0002, Output_IF_PC=0000.
REQ-034 PC=16'hFFFE, fetch with MemReady after 3 cycles -> MemReq high 3 cycles, Output_IF_PC=FFFE, PC=0000, PCNext=0002.
REQ-035 PCWrite target 16'h1235 with start in IDLE same cycle -> MemAddr=1234, after capture PC=1236.
REQ-036 PCWrite target 16'h0400 during WAIT at addr 0010 -> MemAddr stays 0010, after capture PC=0400.
REQ-037 MemReady never asserted, TIMEOUT=15 -> Fault=1 after 15 WAIT cycles, MemReq=0, start ignored; PCWrite 16'h0020 -> Fault=0, IDLE, PC=0020.
REQ-038 RST_N low mid-WAIT, MemReady=1 next cycle -> MemReq=0 immediately, no IRWrite, PC=RESET_PC.
